// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory port controller.
// The one-hot grant bit positions are shared by the arbiter and the top.
package dm_pkg;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_LSU,
        OWN_DMA
    } owner_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ST,
        GNT_LD,
        GNT_DMA
    } grant_t;

    localparam int GI_ST  = 0;
    localparam int GI_LD  = 1;
    localparam int GI_DMA = 2;

    // Expand active-low byte strobes into active-low SRAM bit enables.
    function automatic logic [31:0] strb_to_bweb(input logic [3:0] strb);
        logic [31:0] bweb;
        for (int n = 0; n < 4; n++) begin
            bweb[8*n +: 8] = {8{strb[n]}};
        end
        return bweb;
    endfunction

endpackage

// File: rtl/dm_age_arb.sv
// Fixed-priority arbiter (store > load > DMA) for the data-memory port.
// A DMA request that keeps losing is forced through once it has waited MAX_STARVE cycles.
module dm_age_arb
    import dm_pkg::*;
#(
    parameter int MAX_STARVE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       store_valid,
    input  logic       load_valid,
    input  logic       dma_valid,
    input  logic       port_free,
    output logic [2:0] grant
);

    localparam int CW = $clog2(MAX_STARVE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STARVE);

    logic [CW-1:0] starve_cnt;
    logic          force_dma;

    assign force_dma = dma_valid && (starve_cnt == CNT_MAX);

    always_comb begin
        grant = '0;
        if (port_free && !rst) begin
            if (force_dma) begin
                grant[GI_DMA] = 1'b1;
            end else if (store_valid) begin
                grant[GI_ST] = 1'b1;
            end else if (load_valid) begin
                grant[GI_LD] = 1'b1;
            end else if (dma_valid) begin
                grant[GI_DMA] = 1'b1;
            end
        end
    end

    // Counts cycles a DMA request sits un-granted; any gap in the request restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!dma_valid || grant[GI_DMA]) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dm_port_ctrl.sv
// Single-port data-memory SRAM controller: arbitrates LSU store/load and DMA,
// drives SRAM strobes, and returns fixed-latency read data to the requester that issued it.
module dm_port_ctrl
    import dm_pkg::*;
#(
    parameter int DM_AW      = 14,
    parameter int RD_LAT     = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ld_st_req_addr,
    input  logic             store_req_valid,
    output logic             store_req_ready,
    input  logic [3:0]       store_strb,
    input  logic [31:0]      store_data,
    output logic             store_data_valid,
    input  logic             load_req_valid,
    output logic             load_req_ready,
    output logic             load_data_valid,
    output logic [31:0]      load_data,
    input  logic             dma_req_valid,
    output logic             dma_req_ready,
    input  logic             dma_req_we,
    input  logic [31:0]      dma_req_addr,
    input  logic [31:0]      dma_req_wdata,
    output logic             dma_rdata_valid,
    output logic [31:0]      dma_rdata,
    output logic             dm_ceb,
    output logic             dm_web,
    output logic [31:0]      dm_bweb,
    output logic [DM_AW-1:0] dm_a,
    output logic [31:0]      dm_di,
    input  logic [31:0]      dm_do
);

    localparam int LW = $clog2(RD_LAT + 1);
    localparam logic [LW-1:0] LAT_ONE = LW'(1);

    state_t      state;
    state_t      state_nxt;
    owner_t      rd_owner;
    logic [LW-1:0] lat_cnt;
    logic        st_done;
    logic [2:0]  grant_oh;
    grant_t      gnt;
    logic        gnt_rd;
    logic        rd_ret;
    logic        port_free;
    logic        unused_addr;

    // Only the word-address field of each byte address reaches the SRAM.
    assign unused_addr = ^{ld_st_req_addr, dma_req_addr};

    // The final latency cycle frees the port so a new access can overlap the return.
    assign rd_ret    = (state == RD_WAIT) && (lat_cnt == LAT_ONE);
    assign port_free = (state == IDLE) || rd_ret;

    dm_age_arb #(
        .MAX_STARVE (MAX_STARVE)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .store_valid (store_req_valid),
        .load_valid  (load_req_valid),
        .dma_valid   (dma_req_valid),
        .port_free   (port_free),
        .grant       (grant_oh)
    );

    always_comb begin
        gnt = GNT_NONE;
        if (grant_oh[GI_ST]) begin
            gnt = GNT_ST;
        end else if (grant_oh[GI_LD]) begin
            gnt = GNT_LD;
        end else if (grant_oh[GI_DMA]) begin
            gnt = GNT_DMA;
        end
    end

    assign gnt_rd = (gnt == GNT_LD) || ((gnt == GNT_DMA) && !dma_req_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_rd) state_nxt = RD_WAIT;
            RD_WAIT: if (rd_ret) state_nxt = gnt_rd ? RD_WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt  <= '0;
            rd_owner <= OWN_NONE;
            st_done  <= 1'b0;
        end else begin
            st_done <= (gnt == GNT_ST);
            if (gnt_rd) begin
                lat_cnt  <= LW'(RD_LAT);
                rd_owner <= (gnt == GNT_LD) ? OWN_LSU : OWN_DMA;
            end else if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
                if (lat_cnt == LAT_ONE) rd_owner <= OWN_NONE;
            end
        end
    end

    always_comb begin
        store_req_ready  = (gnt == GNT_ST);
        load_req_ready   = (gnt == GNT_LD);
        dma_req_ready    = (gnt == GNT_DMA);
        store_data_valid = st_done && !rst;
        load_data_valid  = rd_ret && (rd_owner == OWN_LSU) && !rst;
        dma_rdata_valid  = rd_ret && (rd_owner == OWN_DMA) && !rst;
        load_data        = load_data_valid ? dm_do : '0;
        dma_rdata        = dma_rdata_valid ? dm_do : '0;
        dm_ceb           = 1'b1;
        dm_web           = 1'b1;
        dm_bweb          = '1;
        dm_a             = '0;
        dm_di            = '0;
        case (gnt)
            GNT_ST: begin
                dm_ceb  = 1'b0;
                dm_web  = 1'b0;
                dm_bweb = strb_to_bweb(store_strb);
                dm_a    = ld_st_req_addr[DM_AW+1:2];
                dm_di   = store_data;
            end
            GNT_LD: begin
                dm_ceb = 1'b0;
                dm_a   = ld_st_req_addr[DM_AW+1:2];
            end
            GNT_DMA: begin
                dm_ceb = 1'b0;
                dm_a   = dma_req_addr[DM_AW+1:2];
                if (dma_req_we) begin
                    dm_web  = 1'b0;
                    dm_bweb = '0;
                    dm_di   = dma_req_wdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_port_ctrl.sv
// Directed bench for dm_port_ctrl: three instances (RD_LAT = 1, 2, 3) share one stimulus set,
// and each scenario starts from reset and checks the instance whose latency it targets.
module tb_dm_port_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] ld_st_req_addr;
    logic        store_req_valid;
    logic [3:0]  store_strb;
    logic [31:0] store_data;
    logic        load_req_valid;
    logic        dma_req_valid;
    logic        dma_req_we;
    logic [31:0] dma_req_addr;
    logic [31:0] dma_req_wdata;
    logic [31:0] dm_do;

    logic [2:0]  st_rdy;
    logic [2:0]  st_dv;
    logic [2:0]  ld_rdy;
    logic [2:0]  ld_dv;
    logic [2:0]  dma_rdy;
    logic [2:0]  dma_dv;
    logic [2:0]  ceb;
    logic [2:0]  web;
    logic [31:0] ld_data  [3];
    logic [31:0] dma_data [3];
    logic [31:0] bweb     [3];
    logic [13:0] addr     [3];
    logic [31:0] di       [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dm_port_ctrl #(
            .DM_AW      (14),
            .RD_LAT     (g + 1),
            .MAX_STARVE (4)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .ld_st_req_addr   (ld_st_req_addr),
            .store_req_valid  (store_req_valid),
            .store_req_ready  (st_rdy[g]),
            .store_strb       (store_strb),
            .store_data       (store_data),
            .store_data_valid (st_dv[g]),
            .load_req_valid   (load_req_valid),
            .load_req_ready   (ld_rdy[g]),
            .load_data_valid  (ld_dv[g]),
            .load_data        (ld_data[g]),
            .dma_req_valid    (dma_req_valid),
            .dma_req_ready    (dma_rdy[g]),
            .dma_req_we       (dma_req_we),
            .dma_req_addr     (dma_req_addr),
            .dma_req_wdata    (dma_req_wdata),
            .dma_rdata_valid  (dma_dv[g]),
            .dma_rdata        (dma_data[g]),
            .dm_ceb           (ceb[g]),
            .dm_web           (web[g]),
            .dm_bweb          (bweb[g]),
            .dm_a             (addr[g]),
            .dm_di            (di[g]),
            .dm_do            (dm_do)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        store_req_valid = 1'b0;
        load_req_valid  = 1'b0;
        dma_req_valid   = 1'b0;
        dma_req_we      = 1'b0;
        ld_st_req_addr  = '0;
        store_strb      = 4'hF;
        store_data      = '0;
        dma_req_addr    = '0;
        dma_req_wdata   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        dm_do = '0;
        idle_inputs();

        // Reset: readys stay low even with every request raised.
        step();
        store_req_valid = 1'b1;
        load_req_valid  = 1'b1;
        dma_req_valid   = 1'b1;
        #1;
        chk("rst_st_rdy",  {29'b0, st_rdy},  32'h0);
        chk("rst_ld_rdy",  {29'b0, ld_rdy},  32'h0);
        chk("rst_dma_rdy", {29'b0, dma_rdy}, 32'h0);
        chk("rst_ceb",     {29'b0, ceb},     32'h7);
        step();
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("post_rst_ceb",  ceb[0],  1'b1);
        chk("post_rst_web",  web[0],  1'b1);
        chk("post_rst_bweb", bweb[0], 32'hFFFF_FFFF);
        chk("post_rst_a",    {18'b0, addr[0]}, 32'h0);
        chk("post_rst_di",   di[0],   32'h0);
        chk("post_rst_vld",  {29'b0, st_dv[0], ld_dv[0], dma_dv[0]}, 32'h0);

        // Byte store: strobe 1101 enables only byte 1.
        ld_st_req_addr  = 32'h0000_0105;
        store_strb      = 4'b1101;
        store_data      = 32'h0000_AB00;
        store_req_valid = 1'b1;
        #1;
        chk("st_ready", st_rdy[0], 1'b1);
        chk("st_ceb",   ceb[0],    1'b0);
        chk("st_web",   web[0],    1'b0);
        chk("st_a",     {18'b0, addr[0]}, 32'h0000_0041);
        chk("st_bweb",  bweb[0],   32'hFFFF_00FF);
        chk("st_di",    di[0],     32'h0000_AB00);
        step();
        idle_inputs();
        #1;
        chk("st_dvalid", st_dv[0], 1'b1);
        chk("st_idle_ceb", ceb[0], 1'b1);
        step();
        chk("st_dvalid_pulse", st_dv[0], 1'b0);

        // Load with RD_LAT=1.
        do_reset();
        ld_st_req_addr = 32'h0000_0040;
        load_req_valid = 1'b1;
        #1;
        chk("ld1_ready", ld_rdy[0], 1'b1);
        chk("ld1_a",     {18'b0, addr[0]}, 32'h0000_0010);
        chk("ld1_web",   web[0],  1'b1);
        chk("ld1_ceb",   ceb[0],  1'b0);
        chk("ld1_bweb",  bweb[0], 32'hFFFF_FFFF);
        step();
        idle_inputs();
        dm_do = 32'hDEAD_BEEF;
        #1;
        chk("ld1_dvalid", ld_dv[0],   1'b1);
        chk("ld1_data",   ld_data[0], 32'hDEAD_BEEF);
        chk("ld1_no_dma_dv", dma_dv[0], 1'b0);
        step();
        chk("ld1_dvalid_pulse", ld_dv[0], 1'b0);

        // Store and load together: store first, load next cycle.
        do_reset();
        ld_st_req_addr  = 32'h0000_0010;
        store_strb      = 4'b0000;
        store_data      = 32'h1111_2222;
        store_req_valid = 1'b1;
        load_req_valid  = 1'b1;
        #1;
        chk("both_st_rdy", st_rdy[0], 1'b1);
        chk("both_ld_rdy", ld_rdy[0], 1'b0);
        step();
        store_req_valid = 1'b0;
        #1;
        chk("both_ld_rdy_next", ld_rdy[0], 1'b1);
        chk("both_st_rdy_next", st_rdy[0], 1'b0);
        step();
        idle_inputs();

        // DMA starvation: forced through on the 5th waiting cycle, and again 5 cycles later.
        do_reset();
        ld_st_req_addr  = 32'h0000_0000;
        store_strb      = 4'b0000;
        store_data      = 32'h5555_AAAA;
        store_req_valid = 1'b1;
        dma_req_valid   = 1'b1;
        dma_req_we      = 1'b1;
        dma_req_addr    = 32'h0000_0200;
        dma_req_wdata   = 32'h1234_5678;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (k == 5 || k == 10) begin
                chk($sformatf("starve_dma_rdy_%0d", k), dma_rdy[0], 1'b1);
                chk($sformatf("starve_st_rdy_%0d", k),  st_rdy[0],  1'b0);
            end else begin
                chk($sformatf("starve_dma_rdy_%0d", k), dma_rdy[0], 1'b0);
                chk($sformatf("starve_st_rdy_%0d", k),  st_rdy[0],  1'b1);
            end
            if (k == 5) begin
                chk("starve_dma_a",    {18'b0, addr[0]}, 32'h0000_0080);
                chk("starve_dma_web",  web[0],  1'b0);
                chk("starve_dma_bweb", bweb[0], 32'h0000_0000);
                chk("starve_dma_di",   di[0],   32'h1234_5678);
            end
            step();
        end
        idle_inputs();

        // RD_LAT=3: load then DMA read, port blocked while the load is in flight.
        do_reset();
        ld_st_req_addr = 32'h0000_0040;
        load_req_valid = 1'b1;
        dma_req_valid  = 1'b1;
        dma_req_we     = 1'b0;
        dma_req_addr   = 32'h0000_0080;
        #1;
        chk("lat3_ld_rdy",  ld_rdy[2],  1'b1);
        chk("lat3_dma_rdy0", dma_rdy[2], 1'b0);
        step();
        load_req_valid = 1'b0;
        #1;
        chk("lat3_blk1_dma", dma_rdy[2], 1'b0);
        chk("lat3_blk1_ceb", ceb[2],     1'b1);
        step();
        chk("lat3_blk2_dma", dma_rdy[2], 1'b0);
        chk("lat3_blk2_ld_dv", ld_dv[2], 1'b0);
        step();
        dm_do = 32'hCAFE_F00D;
        #1;
        chk("lat3_ld_dv",   ld_dv[2],   1'b1);
        chk("lat3_ld_data", ld_data[2], 32'hCAFE_F00D);
        chk("lat3_dma_rdy", dma_rdy[2], 1'b1);
        chk("lat3_dma_a",   {18'b0, addr[2]}, 32'h0000_0020);
        chk("lat3_dma_web", web[2],     1'b1);
        step();
        dma_req_valid = 1'b0;
        #1;
        chk("lat3_dma_dv_g4", dma_dv[2], 1'b0);
        chk("lat3_ld_dv_g4",  ld_dv[2],  1'b0);
        step();
        chk("lat3_dma_dv_g5", dma_dv[2], 1'b0);
        step();
        dm_do = 32'h0BAD_C0DE;
        #1;
        chk("lat3_dma_dv",   dma_dv[2],   1'b1);
        chk("lat3_dma_data", dma_data[2], 32'h0BAD_C0DE);
        chk("lat3_dma_ld_dv", ld_dv[2],   1'b0);
        step();
        idle_inputs();

        // RD_LAT=2: reset one cycle after the load grant discards the read.
        do_reset();
        ld_st_req_addr = 32'h0000_0040;
        load_req_valid = 1'b1;
        #1;
        chk("midrst_ld_rdy", ld_rdy[1], 1'b1);
        step();
        load_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_dv_in_rst", ld_dv[1], 1'b0);
        step();
        rst = 1'b0;
        dm_do = 32'h7777_7777;
        #1;
        chk("midrst_no_dv",  ld_dv[1], 1'b0);
        chk("midrst_ceb",    ceb[1],   1'b1);
        chk("midrst_bweb",   bweb[1],  32'hFFFF_FFFF);
        chk("midrst_readys", {29'b0, st_rdy[1], ld_rdy[1], dma_rdy[1]}, 32'h0);
        step();
        chk("midrst_no_dv_late", ld_dv[1], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
